// File: rtl/sdrc_wb_pkg.sv
// Shared constants and types for the SDRAM-side Wishbone burst master.
package sdrc_wb_pkg;

   // Wishbone cycle-type tags
   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_EOB     = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      READ   = 2'd2,
      FINISH = 2'd3
   } wbm_state_t;

endpackage

// File: rtl/sdrc_wb_burst_master_if.sv
// Wishbone bus bundle between the burst master and the SDRAM controller slave port.
interface sdrc_wb_burst_master_if #(
   parameter int dw     = 32,
   parameter int APP_AW = 26
);
   logic              wb_cyc_o;
   logic              wb_stb_o;
   logic              wb_we_o;
   logic [APP_AW-1:0] wb_addr_o;
   logic [dw-1:0]     wb_dat_o;
   logic [dw/8-1:0]   wb_sel_o;
   logic [2:0]        wb_cti_o;
   logic              wb_ack_i;
   logic [dw-1:0]     wb_dat_i;

   modport master (
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      input  wb_ack_i, wb_dat_i
   );

   modport slave (
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
      output wb_ack_i, wb_dat_i
   );
endinterface

// File: rtl/sdrc_wb_rdfifo.sv
// Read-data FIFO: register-based storage, head word presented directly from the array.
module sdrc_wb_rdfifo #(
   parameter int dw         = 32,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          push,
   input  logic [dw-1:0]                 din,
   input  logic                          pop,
   output logic [dw-1:0]                 dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [dw-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_push;
   logic          do_pop;

   // Extra pointer MSB distinguishes full from empty when the indices match
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Pointer advance and storage write; storage clears so the head reads zero out of reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/sdrc_wb_burst_master.sv
// Wishbone incrementing-burst master feeding the SDRAM controller slave port.
// Commands arrive on a valid/ready port; write beats stream in, read beats
// stream out through a small FIFO so the consumer may stall freely.
module sdrc_wb_burst_master
   import sdrc_wb_pkg::*;
#(
   parameter int dw         = 32,
   parameter int APP_AW     = 26,
   parameter int BL_W       = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 sys_clk,
   input  logic                 resetn,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wr,
   input  logic [APP_AW-1:0]    req_addr,
   input  logic [BL_W-1:0]      req_len,
   input  logic                 wdat_valid,
   output logic                 wdat_ready,
   input  logic [dw-1:0]        wdat,
   input  logic [dw/8-1:0]      wdat_sel,
   output logic                 rdat_valid,
   input  logic                 rdat_ready,
   output logic [dw-1:0]        rdat,
   output logic                 done,
   sdrc_wb_burst_master_if.master wb
);
   localparam int                CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BL_W:0]     ONE     = 1;
   localparam logic [APP_AW-1:0] ONE_A   = 1;
   localparam logic [CW:0]       DEPTH_V = (CW+1)'(FIFO_DEPTH);

   wbm_state_t    state, state_nxt;
   logic [BL_W:0] beats_left;   // acks still owed for this burst
   logic [BL_W:0] fetch_left;   // beats not yet placed on the bus
   logic [BL_W:0] len_beats;
   logic          accept;
   logic          beat_done;
   logic          last_beat;
   logic          wload;
   logic          rd_issue;
   logic          beat_issue;
   logic          rd_space;
   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW:0]   occ_nxt;

   assign len_beats  = {1'b0, req_len} + ONE;
   assign req_ready  = (state == IDLE);
   assign accept     = req_valid & req_ready;
   assign beat_done  = wb.wb_stb_o & wb.wb_ack_i;
   assign last_beat  = beat_done & (beats_left == ONE);

   assign wdat_ready = (state == WRITE) & (fetch_left != '0) & (~wb.wb_stb_o | wb.wb_ack_i);
   assign wload      = wdat_valid & wdat_ready;

   // Occupancy after this edge; a new read beat is only issued if it will have a slot
   assign occ_nxt    = {1'b0, fifo_count} + {{CW{1'b0}}, fifo_push} - {{CW{1'b0}}, fifo_pop};
   assign rd_space   = (occ_nxt < DEPTH_V) & ~(fifo_full & ~fifo_pop);
   assign rd_issue   = (state == READ) & (fetch_left != '0) & (~wb.wb_stb_o | wb.wb_ack_i) & rd_space;
   assign beat_issue = wload | rd_issue;

   assign fifo_push  = (state == READ) & beat_done;
   assign fifo_pop   = rdat_ready & ~fifo_empty;
   assign rdat_valid = ~fifo_empty;

   sdrc_wb_rdfifo #(
      .dw         (dw),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rdfifo (
      .clk   (sys_clk),
      .rst_n (resetn),
      .push  (fifo_push),
      .din   (wb.wb_dat_i),
      .pop   (fifo_pop),
      .dout  (rdat),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // State register
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   // Next-state: accept picks direction, last ack ends the burst, one FINISH cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:        if (accept) state_nxt = req_wr ? WRITE : READ;
         WRITE, READ: if (last_beat) state_nxt = FINISH;
         FINISH:      state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
   end

   // Registered Wishbone outputs, beat counters and completion pulse
   always_ff @(posedge sys_clk or negedge resetn) begin
      if (!resetn) begin
         wb.wb_cyc_o  <= 1'b0;
         wb.wb_stb_o  <= 1'b0;
         wb.wb_we_o   <= 1'b0;
         wb.wb_addr_o <= '0;
         wb.wb_dat_o  <= '0;
         wb.wb_sel_o  <= '0;
         wb.wb_cti_o  <= CTI_CLASSIC;
         beats_left   <= '0;
         fetch_left   <= '0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  wb.wb_addr_o <= req_addr;
                  wb.wb_we_o   <= req_wr;
                  wb.wb_cyc_o  <= 1'b1;
                  beats_left   <= len_beats;
                  // Reads strobe straight away when the FIFO can take the beat
                  if (!req_wr && rd_space) begin
                     wb.wb_stb_o <= 1'b1;
                     wb.wb_cti_o <= (req_len == '0) ? CTI_EOB : CTI_INCR;
                     fetch_left  <= {1'b0, req_len};
                  end else begin
                     fetch_left  <= len_beats;
                  end
               end
            end
            WRITE, READ: begin
               if (beat_done) begin
                  wb.wb_addr_o <= wb.wb_addr_o + ONE_A;
                  beats_left   <= beats_left - ONE;
               end
               if (beat_issue) begin
                  wb.wb_stb_o <= 1'b1;
                  wb.wb_cti_o <= (fetch_left == ONE) ? CTI_EOB : CTI_INCR;
                  fetch_left  <= fetch_left - ONE;
               end else if (beat_done) begin
                  wb.wb_stb_o <= 1'b0;
               end
               if (wload) begin
                  wb.wb_dat_o <= wdat;
                  wb.wb_sel_o <= wdat_sel;
               end
               if (last_beat) begin
                  wb.wb_cyc_o <= 1'b0;
                  wb.wb_stb_o <= 1'b0;
                  done        <= 1'b1;
               end
            end
            FINISH: begin
               wb.wb_cti_o <= CTI_CLASSIC;
               wb.wb_we_o  <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/sdrc_wb_burst_master.md
# sdrc_wb_burst_master

Wishbone bus master that sits directly upstream of the SDRAM controller's Wishbone slave port. It accepts burst requests on a simple valid/ready command port and streams write data in, or read data out, per beat. It generates registered Wishbone incrementing-burst cycles with `cti` tagging. A small internal read FIFO absorbs read data so the consumer can apply backpressure without violating Wishbone.

## Interface
Parameters:
- `dw`, 32, Wishbone data width; `dw/8` byte selects
- `APP_AW`, 26, application/Wishbone word-address width
- `BL_W`, 8, burst-length field width; beats = `req_len`+1 (1..2^BL_W)
- `FIFO_DEPTH`, 16, read FIFO entries (power of two, ≥2)

Ports:
- `sys_clk`  in  1  single clock; all logic rising-edge
- `resetn`  in  1  asynchronous, active-low reset
- `req_valid`/`req_ready`  in/out  1  command handshake; `req_ready` = state IDLE
- `req_wr`  in  1  1 = write burst, 0 = read burst
- `req_addr`  in  APP_AW  first word address
- `req_len`  in  BL_W  beats minus one
- `wdat_valid`/`wdat_ready`  in/out  1  write-data handshake
- `wdat`, `wdat_sel`  in  dw, dw/8  write beat and byte enables
- `rdat_valid`/`rdat_ready`  out/in  1  read-data handshake (FIFO head)
- `rdat`  out  dw  read beat
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone cycle/strobe/write
- `wb_addr_o`  out  APP_AW; `wb_dat_o`  out  dw; `wb_sel_o`  out  dw/8; `wb_cti_o`  out  3
- `wb_ack_i`  in  1; `wb_dat_i`  in  dw
- `done`  out  1  one-cycle pulse at burst completion

## Operation
- States: IDLE → WRITE or READ (on `req_valid&req_ready`, per `req_wr`) → FINISH → IDLE.
- On accept: latch address, beat counter = `req_len`+1, `wb_we_o`=`req_wr`, `wb_cyc_o`=1.
- A beat completes on `wb_stb_o & wb_ack_i`; address then increments by 1, wrapping mod 2^APP_AW; counter decrements.
- `wb_cti_o`=3'b010 on every beat except the last, which gets 3'b111. A single-beat burst gets 3'b111.
- WRITE: a beat register loads `wdat`/`wdat_sel` when `wdat_valid & wdat_ready`.
  - `wdat_ready` = WRITE & beats remaining to fetch & (!`wb_stb_o` | `wb_ack_i`).
  - `wb_stb_o` is high while the register holds a beat. Back-to-back load on the ack cycle is allowed.
- READ: on each completing beat, `wb_dat_i` is pushed into the read FIFO.
  - A new beat (stb) is issued only while FIFO occupancy plus the in-flight beat < FIFO_DEPTH.
  - Simultaneous push/pop at full is legal.
- Once raised, `wb_stb_o` is never dropped before ack.
- FINISH (cycle after last ack): `wb_cyc_o`=`wb_stb_o`=0, `done`=1, then IDLE. The read FIFO may still hold data; a new request is accepted regardless.
- `wdat_valid` outside WRITE is ignored (not consumed).

## Timing
- Reset (async, `resetn`=0) values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`, `wb_addr_o`, `wb_dat_o`, `wb_sel_o`, `wb_cti_o`, `done`, `wdat_ready`, `rdat_valid`, `rdat` = 0
  - `req_ready`=1
- Reset mid-burst: outputs clear immediately, FIFO empties, state → IDLE; the burst is abandoned.
- Accept at cycle T:
  - `wb_cyc_o` rises T+1.
  - Read: `wb_stb_o` rises T+1.
  - Write: first `wdat_ready` at T+1; `wb_stb_o` rises the cycle after the first load (≥T+2).
- Zero-wait slave: one beat per cycle in both directions.
- Last ack at cycle C: `done`=1 and cyc=0 in C+1; `req_ready`=1 at C+2.
- Read data: pushed at the ack edge; `rdat_valid` is high the next cycle (1-cycle latency). FIFO is first-word registered.

## Structure
- Package `sdrc_wb_pkg`:
  - `cti` constants: CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111.
  - State enum `wbm_state_t` {IDLE, WRITE, READ, FINISH}.
- Sub-module `sdrc_wb_rdfifo`: synchronous FIFO with parameters `dw` and `FIFO_DEPTH`.
  - Ports: push, pop, full, empty, count.
  - Pointers are log2(DEPTH)+1 bits.

## Test plan
- Write, `req_addr`=0x100, `req_len`=3, data 0xA0..0xA3, ack every cycle:
  - 4 beats at addr 0x100..0x103; cti 010,010,010,111.
  - `done` one cycle after the last ack.
- Read, `req_len`=0, `wb_dat_i`=0xDEADBEEF: single beat with cti 111; `rdat`=0xDEADBEEF one cycle after ack.
- Read `req_len`=31, `rdat_ready`=0 throughout: exactly FIFO_DEPTH acks; stb never drops mid-beat.
  - Then `rdat_ready`=1: the remaining 16 beats complete; all 32 values arrive in order.
- Write with `wdat_valid` gapped 1-of-3 cycles and random ack delays (0-3): no beat is lost or duplicated; `wdat_sel` is carried per beat.
- Read at `req_addr`=0x3FFFFFE, `req_len`=3: addresses 0x3FFFFFE, 0x3FFFFFF, 0x0, 0x1.
- `resetn` asserted mid-write after beat 2: cyc/stb are 0 the same cycle, `req_ready`=1. A following read burst completes normally.
